// File: rtl/thread_fetch_scheduler_if.sv
// Bus between the fine-grained multithreading fetch scheduler and the core:
// run control, start/halt, next-PC writeback in; issue stream and status out.
interface thread_fetch_scheduler_if #(
  parameter int NTHREADS = 8,
  parameter int TIDW     = $clog2(NTHREADS),
  parameter int AW       = 32
);
  logic                en;
  logic                start_valid;
  logic [TIDW-1:0]     start_tid;
  logic [AW-1:0]       start_pc;
  logic                halt_valid;
  logic [TIDW-1:0]     halt_tid;
  logic                wb_valid;
  logic [TIDW-1:0]     wb_tid;
  logic [AW-1:0]       wb_pc;
  logic                issue_valid;
  logic [TIDW-1:0]     issue_tid;
  logic [AW-1:0]       issue_pc;
  logic [NTHREADS-1:0] active_mask;
  logic                wb_err;

  modport master (
    output en, start_valid, start_tid, start_pc, halt_valid, halt_tid,
           wb_valid, wb_tid, wb_pc,
    input  issue_valid, issue_tid, issue_pc, active_mask, wb_err
  );

  modport slave (
    input  en, start_valid, start_tid, start_pc, halt_valid, halt_tid,
           wb_valid, wb_tid, wb_pc,
    output issue_valid, issue_tid, issue_pc, active_mask, wb_err
  );
endinterface

// File: rtl/thread_fetch_scheduler.sv
// Round-robin per-thread PC fetch scheduler, one instruction in flight per thread.
// Define THREAD_SKIP_EN for work-conserving selection; default is strict barrel rotation.
module thread_fetch_scheduler #(
  parameter int                  NTHREADS   = 8,
  parameter int                  TIDW       = $clog2(NTHREADS),
  parameter int                  AW         = 32,
  parameter logic [AW-1:0]       RESET_PC   = 32'h0000_0000,
  parameter logic [AW-1:0]       PC_STRIDE  = 32'h0000_1000,
  parameter logic [NTHREADS-1:0] RESET_MASK = '1
) (
  input logic                  clk,
  input logic                  reset,
  thread_fetch_scheduler_if.slave bus
);

  typedef logic [NTHREADS-1:0][AW-1:0] pcVecT;

  function automatic pcVecT resetPcs();
    pcVecT v;
    for (int t = 0; t < NTHREADS; t++) begin
      v[t] = RESET_PC + AW'(t) * PC_STRIDE;
    end
    return v;
  endfunction

  pcVecT               pcR;
  pcVecT               pcNextS;
  logic [NTHREADS-1:0] activeR;
  logic [NTHREADS-1:0] activeNextS;
  logic [NTHREADS-1:0] pendingR;
  logic [NTHREADS-1:0] pendingNextS;
  logic [NTHREADS-1:0] eligibleS;
  logic [TIDW-1:0]     ptrR;
  logic [TIDW-1:0]     ptrNextS;
  logic [TIDW-1:0]     selTidS;
  logic                selFoundS;
  logic                issueFireS;
  logic                wbAcceptS;
  logic                startAcceptS;
  logic                issueValidR;
  logic [TIDW-1:0]     issueTidR;
  logic [AW-1:0]       issuePcR;
  logic                wbErrR;

  // Eligibility is taken from registered state only; same-cycle wb/start/halt do not bypass.
  assign eligibleS = activeR & ~pendingR;

`ifdef THREAD_SKIP_EN
  // Pick the first eligible thread after ptr, wrapping; ptr only advances on an issue.
  always_comb begin
    selFoundS = 1'b0;
    selTidS   = ptrR;
    for (int i = 1; i <= NTHREADS; i++) begin
      if (!selFoundS && eligibleS[ptrR + TIDW'(i)]) begin
        selFoundS = 1'b1;
        selTidS   = ptrR + TIDW'(i);
      end else begin
        selFoundS = selFoundS;
      end
    end
    ptrNextS = selFoundS ? selTidS : ptrR;
  end
`else
  // Strict barrel: the slot after ptr issues only if its thread is eligible, otherwise a bubble.
  always_comb begin
    selTidS   = ptrR + TIDW'(1);
    selFoundS = eligibleS[selTidS];
    ptrNextS  = selTidS;
  end
`endif

  // Next-state for per-thread pc/active/pending; halt is applied last so it beats a same-tid start.
  always_comb begin
    issueFireS   = bus.en & selFoundS;
    wbAcceptS    = bus.wb_valid & pendingR[bus.wb_tid];
    startAcceptS = bus.start_valid & ~activeR[bus.start_tid] & ~pendingR[bus.start_tid]
                 & ~(bus.halt_valid & (bus.halt_tid == bus.start_tid));
    pendingNextS = pendingR;
    activeNextS  = activeR;
    pcNextS      = pcR;
    for (int t = 0; t < NTHREADS; t++) begin
      pendingNextS[t] = (pendingR[t] | (issueFireS & (selTidS == TIDW'(t))))
                      & ~(wbAcceptS & (bus.wb_tid == TIDW'(t)));
      activeNextS[t]  = (activeR[t] | (startAcceptS & (bus.start_tid == TIDW'(t))))
                      & ~(bus.halt_valid & (bus.halt_tid == TIDW'(t)));
      pcNextS[t]      = (wbAcceptS & (bus.wb_tid == TIDW'(t)))       ? bus.wb_pc    :
                        (startAcceptS & (bus.start_tid == TIDW'(t))) ? bus.start_pc :
                                                                       pcR[t];
    end
  end

  // Thread state, pointer and registered issue/status outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptrR        <= TIDW'(NTHREADS - 1);
      issueValidR <= 1'b0;
      issueTidR   <= '0;
      issuePcR    <= '0;
      wbErrR      <= 1'b0;
      pendingR    <= '0;
      activeR     <= RESET_MASK;
      pcR         <= resetPcs();
    end else begin
      wbErrR   <= bus.wb_valid & ~pendingR[bus.wb_tid];
      pendingR <= pendingNextS;
      activeR  <= activeNextS;
      pcR      <= pcNextS;
      if (bus.en) begin
        ptrR        <= ptrNextS;
        issueValidR <= selFoundS;
        if (selFoundS) begin
          issueTidR <= selTidS;
          issuePcR  <= pcR[selTidS];
        end
      end
    end
  end

  assign bus.issue_valid = issueValidR;
  assign bus.issue_tid   = issueTidR;
  assign bus.issue_pc    = issuePcR;
  assign bus.active_mask = activeR;
  assign bus.wb_err      = wbErrR;

endmodule
